// File: rtl/transport_pkg.sv
// Shared definitions for the transport send and receive paths: packet
// headers, session strobe codes and the packetizer state encoding.
package transport_pkg;

  localparam logic [7:0] HDR_CONTROL  = 8'h40;
  localparam logic [7:0] HDR_AUDIO    = 8'h80;

  localparam logic [1:0] SEND_CONTROL = 2'b01;
  localparam logic [1:0] SEND_AUDIO   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_PAD  = 3'd4
  } state_t;

  typedef enum logic {
    PKT_CONTROL = 1'b0,
    PKT_AUDIO   = 1'b1
  } pkt_t;

endpackage

// File: rtl/word_fifo.sv
// 16-bit synchronous FIFO with show-ahead read data. A write is accepted
// when the FIFO is full as long as a read frees a slot in the same cycle.
module word_fifo #(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [15:0]              din,
  output logic [15:0]              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign dout  = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/transport_send.sv
// Packetizer: turns control words (single holding register) and audio words
// (queued in word_fifo) into fixed-length byte packets, one byte per
// un-stalled cycle.
module transport_send
  import transport_pkg::*;
#(
  parameter int packetSize = 16,
  parameter int fifoDepth  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sessionSending,
  input  logic [15:0] sessionData,
  input  logic        networkBusy,
  output logic        sendSignal,
  output logic [7:0]  packetOut,
  output logic        busy,
  output logic        ctrlDrop,
  output logic        audioDrop
);

  localparam int AUDIO_WORDS = (packetSize - 4) / 2;
  localparam int CW = $clog2(fifoDepth) + 1;
  localparam int BW = $clog2(packetSize);
  localparam int WW = $clog2(AUDIO_WORDS + 1);

  state_t         state, state_nxt;
  pkt_t           pkt_type, type_nxt;
  logic [BW-1:0]  byte_cnt, byte_cnt_nxt;
  logic [WW-1:0]  word_cnt, word_cnt_nxt;
  logic           emit;
  logic [7:0]     byte_nxt;
  logic           pop;
  logic           ctrl_clear;

  logic           ctrl_pending;
  logic [15:0]    ctrl_word;

  logic           ctrl_strobe;
  logic           audio_strobe;
  logic [15:0]    fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  assign ctrl_strobe  = (sessionSending == SEND_CONTROL);
  assign audio_strobe = (sessionSending == SEND_AUDIO);
  assign busy         = (state != S_IDLE) || ctrl_pending;

  word_fifo #(.DEPTH(fifoDepth)) u_fifo (
    .clk   (clk),
    .srst  (reset),
    .wr_en (audio_strobe),
    .rd_en (pop),
    .din   (sessionData),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state and emitted byte; every active state stalls while networkBusy.
  always_comb begin
    state_nxt    = state;
    type_nxt     = pkt_type;
    byte_cnt_nxt = byte_cnt;
    word_cnt_nxt = word_cnt;
    emit         = 1'b0;
    byte_nxt     = 8'h00;
    pop          = 1'b0;
    ctrl_clear   = 1'b0;
    case (state)
      S_IDLE: begin
        byte_cnt_nxt = '0;
        word_cnt_nxt = '0;
        if (ctrl_pending) begin
          type_nxt  = PKT_CONTROL;
          state_nxt = S_HDR;
        end else if (fifo_count >= CW'(AUDIO_WORDS)) begin
          type_nxt  = PKT_AUDIO;
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (!networkBusy) begin
          emit      = 1'b1;
          byte_nxt  = (pkt_type == PKT_AUDIO) ? HDR_AUDIO : HDR_CONTROL;
          state_nxt = S_HI;
        end
      end
      S_HI: begin
        if (!networkBusy) begin
          emit      = 1'b1;
          byte_nxt  = (pkt_type == PKT_AUDIO) ? fifo_dout[15:8] : ctrl_word[15:8];
          state_nxt = S_LO;
        end
      end
      S_LO: begin
        if (!networkBusy) begin
          emit = 1'b1;
          if (pkt_type == PKT_AUDIO) begin
            byte_nxt     = fifo_dout[7:0];
            pop          = !fifo_empty;
            word_cnt_nxt = word_cnt + 1'b1;
            state_nxt    = (word_cnt == WW'(AUDIO_WORDS - 1)) ? S_PAD : S_HI;
          end else begin
            byte_nxt   = ctrl_word[7:0];
            ctrl_clear = 1'b1;
            state_nxt  = S_PAD;
          end
        end
      end
      S_PAD: begin
        if (!networkBusy) begin
          emit     = 1'b1;
          byte_nxt = 8'h00;
          if (byte_cnt == BW'(packetSize - 1)) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (emit) byte_cnt_nxt = byte_cnt + 1'b1;
  end

  // State, counters and the registered byte output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pkt_type   <= PKT_CONTROL;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      sendSignal <= 1'b0;
      packetOut  <= 8'h00;
    end else begin
      state      <= state_nxt;
      pkt_type   <= type_nxt;
      byte_cnt   <= byte_cnt_nxt;
      word_cnt   <= word_cnt_nxt;
      sendSignal <= emit;
      if (emit) packetOut <= byte_nxt;
    end
  end

  // Control holding register: first word wins until its packet drains it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_pending <= 1'b0;
      ctrl_word    <= 16'h0000;
      ctrlDrop     <= 1'b0;
    end else begin
      ctrlDrop <= ctrl_strobe && ctrl_pending;
      if (ctrl_strobe && !ctrl_pending) begin
        ctrl_word    <= sessionData;
        ctrl_pending <= 1'b1;
      end else if (ctrl_clear) begin
        ctrl_pending <= 1'b0;
      end
    end
  end

  // Audio drop flag: full FIFO with no same-cycle pop to make room.
  always_ff @(posedge clk) begin
    if (reset) audioDrop <= 1'b0;
    else       audioDrop <= audio_strobe && fifo_full && !pop;
  end

endmodule

// File: tb/tb_transport_send.sv
// Bench for transport_send: collects emitted bytes, parses them into packets
// and compares payloads against queues of words the bench itself pushed.
module tb_transport_send;

  localparam int PKT    = 16;
  localparam int FDEPTH = 32;
  localparam int AW     = (PKT - 4) / 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sessionSending;
  logic [15:0] sessionData;
  logic        networkBusy;
  logic        sendSignal;
  logic [7:0]  packetOut;
  logic        busy;
  logic        ctrlDrop;
  logic        audioDrop;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  got[$];
  logic [7:0]  hdr_seq[$];
  logic [15:0] exp_audio[$];
  logic [15:0] exp_ctrl[$];
  int          ctrl_drops;
  int          audio_drops;
  logic        nb_at_edge;

  always #5 clk = ~clk;

  transport_send #(.packetSize(PKT), .fifoDepth(FDEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .sessionSending (sessionSending),
    .sessionData    (sessionData),
    .networkBusy    (networkBusy),
    .sendSignal     (sendSignal),
    .packetOut      (packetOut),
    .busy           (busy),
    .ctrlDrop       (ctrlDrop),
    .audioDrop      (audioDrop)
  );

  task automatic chk(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  always @(posedge clk) nb_at_edge = networkBusy;

  always @(negedge clk) begin
    if (sendSignal === 1'b1) begin
      got.push_back(packetOut);
      chk("no_emit_while_busy", nb_at_edge, 1'b0);
    end
    if (ctrlDrop === 1'b1)  ctrl_drops++;
    if (audioDrop === 1'b1) audio_drops++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    sessionSending = 2'b00;
    networkBusy    = 1'b0;
    idle(2);
    reset = 1'b0;
    got.delete();
    hdr_seq.delete();
    exp_audio.delete();
    exp_ctrl.delete();
    ctrl_drops  = 0;
    audio_drops = 0;
  endtask

  task automatic send(input logic [1:0] kind, input logic [15:0] d);
    sessionSending = kind;
    sessionData    = d;
    tick();
    sessionSending = 2'b00;
  endtask

  task automatic wait_bytes(input int n, input int budget, input bit rnd);
    int c;
    c = 0;
    while (got.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      if (rnd) networkBusy = ($urandom_range(0, 2) == 0);
      c++;
    end
    networkBusy = 1'b0;
    if (got.size() < n) chk("timeout_bytes", got.size(), n);
  endtask

  // Pops npkt packets off the byte stream and checks each against the
  // expected word queues; leftovers on either side are errors.
  task automatic check_packets(input int npkt);
    logic [7:0]  pkt [PKT];
    logic [31:0] exp_w;
    for (int p = 0; p < npkt; p++) begin
      if (got.size() < PKT) begin
        chk("packet_available", got.size(), PKT);
        return;
      end
      for (int i = 0; i < PKT; i++) pkt[i] = got.pop_front();
      hdr_seq.push_back(pkt[0]);
      if (pkt[0] == 8'h80) begin
        for (int w = 0; w < AW; w++) begin
          exp_w = (exp_audio.size() > 0) ? {16'h0, exp_audio.pop_front()} : 32'h1_0000;
          chk("audio_word", {16'h0, pkt[1 + 2*w], pkt[2 + 2*w]}, exp_w);
        end
        for (int i = 1 + 2*AW; i < PKT; i++) chk("audio_pad", pkt[i], 8'h00);
      end else if (pkt[0] == 8'h40) begin
        exp_w = (exp_ctrl.size() > 0) ? {16'h0, exp_ctrl.pop_front()} : 32'h1_0000;
        chk("ctrl_word", {16'h0, pkt[1], pkt[2]}, exp_w);
        for (int i = 3; i < PKT; i++) chk("ctrl_pad", pkt[i], 8'h00);
      end else begin
        chk("header_known", pkt[0], 8'h40);
      end
    end
    chk("stray_bytes", got.size(), 0);
    chk("audio_words_left", exp_audio.size(), 0);
    chk("ctrl_words_left", exp_ctrl.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          nw, npk, cpos;
    bit          hasc;
    logic [15:0] d;

    reset          = 1'b1;
    sessionSending = 2'b00;
    sessionData    = 16'h0000;
    networkBusy    = 1'b0;
    ctrl_drops     = 0;
    audio_drops    = 0;
    idle(3);
    chk("rst_sendSignal", sendSignal, 1'b0);
    chk("rst_packetOut",  packetOut,  8'h00);
    chk("rst_busy",       busy,       1'b0);
    chk("rst_ctrlDrop",   ctrlDrop,   1'b0);
    chk("rst_audioDrop",  audioDrop,  1'b0);
    do_reset();

    // Control word: header three cycles after the strobe cycle.
    sessionData    = 16'hA55A;
    sessionSending = 2'b01;
    lat = 0;
    while (lat < 10) begin
      tick();
      sessionSending = 2'b00;
      lat++;
      @(negedge clk);
      #1;
      if (sendSignal === 1'b1) break;
    end
    chk("ctrl_hdr_latency", lat, 3);
    chk("busy_in_packet", busy, 1'b1);
    wait_bytes(PKT, 200, 1'b0);
    idle(30);
    chk("ctrl_byte_count", got.size(), PKT);
    exp_ctrl.push_back(16'hA55A);
    check_packets(1);
    chk("busy_after_ctrl", busy, 1'b0);

    // Audio words 1..6 form exactly one packet.
    for (int w = 1; w <= AW; w++) begin
      exp_audio.push_back(16'(w));
      send(2'b10, 16'(w));
    end
    wait_bytes(PKT, 200, 1'b0);
    idle(30);
    chk("audio_byte_count", got.size(), PKT);
    check_packets(1);

    // Five audio words + control: control goes alone, audio waits for word 6.
    hdr_seq.delete();
    for (int w = 0; w < AW - 1; w++) begin
      d = 16'($urandom);
      exp_audio.push_back(d);
      send(2'b10, d);
    end
    d = 16'($urandom);
    exp_ctrl.push_back(d);
    send(2'b01, d);
    wait_bytes(PKT, 200, 1'b0);
    idle(40);
    chk("no_audio_before_full_group", got.size(), PKT);
    d = 16'($urandom);
    exp_audio.push_back(d);
    send(2'b10, d);
    wait_bytes(2*PKT, 200, 1'b0);
    idle(30);
    chk("mixed_byte_count", got.size(), 2*PKT);
    check_packets(2);
    chk("mixed_first_is_ctrl", hdr_seq[0], 8'h40);
    chk("mixed_second_is_audio", hdr_seq[1], 8'h80);

    // Randomized rounds with random backpressure and an optional control word.
    for (int r = 0; r < 8; r++) begin
      nw   = AW * $urandom_range(1, 4);
      cpos = $urandom_range(0, nw);
      hasc = 1'($urandom_range(0, 1));
      npk  = nw / AW + (hasc ? 1 : 0);
      for (int i = 0; i <= nw; i++) begin
        if (hasc && i == cpos) begin
          d = 16'($urandom);
          exp_ctrl.push_back(d);
          networkBusy = ($urandom_range(0, 2) == 0);
          send(2'b01, d);
        end
        if (i < nw) begin
          d = 16'($urandom);
          exp_audio.push_back(d);
          networkBusy = ($urandom_range(0, 2) == 0);
          send(2'b10, d);
          repeat ($urandom_range(0, 2)) begin
            networkBusy = ($urandom_range(0, 2) == 0);
            tick();
          end
        end
      end
      wait_bytes(PKT * npk, 3000, 1'b1);
      idle(40);
      chk("rnd_byte_count", got.size(), PKT * npk);
      check_packets(npk);
    end
    chk("rnd_no_audio_drop", audio_drops, 0);
    chk("rnd_no_ctrl_drop", ctrl_drops, 0);

    // Overflow: 33 words into a 32-deep FIFO, then a second control word.
    do_reset();
    networkBusy = 1'b1;
    for (int i = 0; i < 33; i++) begin
      if (i < 5*AW) exp_audio.push_back(16'h0100 + 16'(i));
      send(2'b10, 16'h0100 + 16'(i));
    end
    send(2'b01, 16'hC0DE);
    send(2'b01, 16'hBAD1);
    exp_ctrl.push_back(16'hC0DE);
    idle(3);
    chk("overflow_audio_drops", audio_drops, 1);
    chk("overflow_ctrl_drops", ctrl_drops, 1);
    chk("nothing_while_busy", got.size(), 0);
    networkBusy = 1'b0;
    wait_bytes(6*PKT, 1000, 1'b0);
    idle(40);
    chk("overflow_byte_count", got.size(), 6*PKT);
    hdr_seq.delete();
    check_packets(6);
    chk("overflow_first_audio", hdr_seq[0], 8'h80);
    chk("overflow_ctrl_next", hdr_seq[1], 8'h40);

    // Reset after the fifth byte abandons the packet; reset-cycle strobes ignored.
    do_reset();
    send(2'b01, 16'h1234);
    wait_bytes(5, 100, 1'b0);
    reset          = 1'b1;
    sessionSending = 2'b01;
    sessionData    = 16'hFFFF;
    tick();
    sessionSending = 2'b10;
    tick();
    sessionSending = 2'b00;
    chk("busy_in_reset", busy, 1'b0);
    reset = 1'b0;
    idle(30);
    chk("reset_abandons_packet", got.size(), 5);
    got.delete();
    send(2'b01, 16'h5AA5);
    exp_ctrl.push_back(16'h5AA5);
    wait_bytes(PKT, 200, 1'b0);
    idle(30);
    chk("post_reset_byte_count", got.size(), PKT);
    check_packets(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/transport_send.md
TRANSPORT_SEND -- requirements
Module: transport_send

Interface
REQ-001 Parameter: packetSize, default 16, packet length in bytes; even, >= 6.
REQ-002 Parameter: fifoDepth, default 32, audio word FIFO depth in 16-bit words; power of two, >= 2*audioWords.
REQ-003 Derived constant: audioWords = (packetSize-4)/2, audio words carried per audio packet.
REQ-004 Port: clk  in  1  sole clock; all logic on posedge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: sessionSending  in  2  word strobe; 2'b01 = control word, 2'b10 = audio word, 2'b00/2'b11 = no word.
REQ-007 Port: sessionData  in  16  word qualified by sessionSending.
REQ-008 Port: networkBusy  in  1  backpressure from the network side; no byte may be emitted while high.
REQ-009 Port: sendSignal  out  1  registered; high for exactly one cycle per emitted byte.
REQ-010 Port: packetOut  out  8  registered byte, valid when sendSignal=1.
REQ-011 Port: busy  out  1  high when the FSM is not in S_IDLE or a control word is pending.
REQ-012 Port: ctrlDrop  out  1  one-cycle pulse when a control word is discarded.
REQ-013 Port: audioDrop  out  1  one-cycle pulse when an audio word is discarded.

Function
REQ-014 The packet format SHALL be: byte 0 = header, then packetSize-1 payload bytes; words are sent high byte first.
REQ-015 A control packet SHALL be: 8'h40, data[15:8], data[7:0], then packetSize-3 bytes of 8'h00.
REQ-016 An audio packet SHALL be: 8'h80, then audioWords words (hi, lo) in FIFO order, then 3 bytes of 8'h00.
REQ-017 A control strobe SHALL load a 16-bit holding register and set ctrlPending; if ctrlPending is already set, the new word SHALL be dropped, the held word kept, and ctrlDrop pulsed.
REQ-018 An audio strobe SHALL push sessionData into the word FIFO; if the FIFO is full and no pop occurs in the same cycle, the word SHALL be dropped and audioDrop pulsed.
REQ-019 A simultaneous push and pop on a full FIFO SHALL succeed, with no drop.
REQ-020 The FSM states SHALL be S_IDLE, S_HDR, S_HI, S_LO, S_PAD.
REQ-021 From S_IDLE: if ctrlPending, go to S_HDR with type=control; else if FIFO count >= audioWords, go to S_HDR with type=audio; otherwise stay in S_IDLE.
REQ-022 Control SHALL have strict priority over audio at packet start; a packet in progress SHALL never be interrupted.
REQ-023 In S_HDR, S_HI, S_LO, and S_PAD, the FSM SHALL emit one byte and advance only on an edge where networkBusy=0; otherwise it SHALL hold state with sendSignal=0.
REQ-024 S_HI SHALL emit the high byte; S_LO SHALL emit the low byte.
REQ-025 For audio, the FIFO pop SHALL occur on the S_LO emit edge; S_LO SHALL return to S_HI until audioWords words have been sent, then go to S_PAD.
REQ-026 For control, S_LO SHALL clear ctrlPending and go to S_PAD.
REQ-027 S_PAD SHALL emit 8'h00 bytes under a byte counter until the total reaches packetSize, then return to S_IDLE.
REQ-028 A back-to-back packet header SHALL NOT be emitted earlier than one cycle after the final pad byte.
REQ-029 Latency: with networkBusy=0 and the FSM idle, the header sendSignal SHALL be high in the third cycle after the strobe cycle (strobe at cycle 0 gives header at cycle 3).
REQ-030 Packet byte count SHALL always be exactly packetSize, independent of backpressure.

Reset
REQ-031 On reset: state=S_IDLE; sendSignal=0; packetOut=8'h00; busy=0; ctrlDrop=0; audioDrop=0; ctrlPending=0; FIFO emptied; byte/word counters=0.
REQ-032 Reset mid-packet SHALL abandon the packet immediately; no further bytes of it SHALL be emitted.
REQ-033 Strobes in the reset cycle SHALL be ignored.

Structure
REQ-034 Package transport_pkg SHALL hold HDR_CONTROL=8'h40, HDR_AUDIO=8'h80, strobe codes SEND_CONTROL=2'b01 and SEND_AUDIO=2'b10, and the state encodings; the receive side shares this package.
REQ-035 Sub-module word_fifo SHALL be a 16-bit synchronous FIFO with srst, wr_en, rd_en, dout, full, empty, and count; the packetizer FSM stays in transport_send.

Verification
REQ-036 Control word 16'hA55A, networkBusy=0 -> 16 sendSignal pulses: 40 A5 5A then 13 x 00; header at cycle 3.
REQ-037 Push 6 audio words 0x0001..0x0006 -> header 80, bytes 00 01 .. 00 06, then 00 00 00; FIFO empty afterwards.
REQ-038 5 audio words queued plus a control strobe -> control packet first; audio packet follows after the 6th audio word arrives.
REQ-039 networkBusy toggled randomly during an audio packet -> byte sequence identical to the unstalled case, with no sendSignal while busy.
REQ-040 33 audio words with no drain (networkBusy=1), then a second control strobe while one is pending -> exactly 1 audioDrop pulse and 1 ctrlDrop pulse; the first control word is kept.
REQ-041 Reset asserted after the 5th byte -> sendSignal=0 from the next cycle; a fresh control packet afterwards is correct.
